// File: rtl/reg_writeback_queue_pkg.sv
// Shared types and widths for the register write-back queue.
package reg_writeback_queue_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // One pending register-file write: destination index plus result value.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_queue_fwd_match.sv
// Youngest-match search over the pending write-back entries for one reader.
module wb_fwd_match
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t [DEPTH-1:0]         entries,
  input  logic [DEPTH-1:0]              valid,
  input  logic [$clog2(DEPTH)-1:0]      head,
  input  logic [REG_AW-1:0]             rs,
  output logic                          hit,
  output logic [XLEN-1:0]               data
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0] idx;

  // Walk from oldest (head) to youngest so the last match seen is the youngest.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[idx] && (rs != '0) && (entries[idx].rd == rs)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
      idx = idx + PTR_ONE;
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// In-order queue between the ALU/load results and the register file write
// port, with forwarding of pending values to the two decode-stage readers.
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [REG_AW-1:0]        mem_rd,
  input  logic [XLEN-1:0]          mem_data,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [REG_AW-1:0]        alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     wb_stall,
  output logic [REG_AW-1:0]        rd,
  output logic [XLEN-1:0]          write_data,
  output logic                     RegWrite,
  input  logic [REG_AW-1:0]        fwd_rs1,
  output logic                     fwd_hit1,
  output logic [XLEN-1:0]          fwd_data1,
  input  logic [REG_AW-1:0]        fwd_rs2,
  output logic                     fwd_hit2,
  output logic [XLEN-1:0]          fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  wb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      fwd_valid;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  not_full, mem_fire, alu_fire, push, pop;
  wb_entry_t             push_entry, head_entry;

  // Arbitration: loads win over ALU results; fullness uses the registered
  // count so a same-cycle pop never makes room for a push.
  always_comb begin
    not_full        = (count_q < CNT_FULL);
    mem_ready       = ~rst & not_full;
    alu_ready       = ~rst & not_full & ~mem_valid;
    mem_fire        = mem_valid & mem_ready;
    alu_fire        = alu_valid & alu_ready;
    push_entry.rd   = mem_fire ? mem_rd   : alu_rd;
    push_entry.data = mem_fire ? mem_data : alu_data;
    push            = (mem_fire | alu_fire) & (push_entry.rd != '0);
    pop             = ~rst & (count_q != '0) & ~wb_stall;
    RegWrite        = pop;
    head_entry      = (count_q != '0) ? entries_q[head_q] : '0;
    rd              = head_entry.rd;
    write_data      = head_entry.data;
    fwd_valid       = rst ? '0 : valid_q;
    count           = count_q;
  end

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    entries_d = entries_q;
    valid_d   = valid_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_ONE;
    end
    if (push) begin
      entries_d[tail_q] = push_entry;
      valid_d[tail_q]   = 1'b1;
      tail_d            = tail_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Queue state registers; reset discards every pending entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payloads need no reset; their valid bits gate all use.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entries (entries_q),
    .valid   (fwd_valid),
    .head    (head_q),
    .rs      (fwd_rs1),
    .hit     (fwd_hit1),
    .data    (fwd_data1)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entries (entries_q),
    .valid   (fwd_valid),
    .head    (head_q),
    .rs      (fwd_rs2),
    .hit     (fwd_hit2),
    .data    (fwd_data2)
  );

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: directed vector table,
// hand-written stall/reset sequences and randomized traffic against a
// queue-based reference model.
module tb_reg_writeback_queue;

  typedef struct {
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        st;
    logic [4:0]  r1;
    logic [4:0]  r2;
  } stim_t;

  typedef struct {
    logic        mr;
    logic        ar;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [2:0]  cnt;
    logic        h1;
    logic [31:0] d1;
    logic        h2;
    logic [31:0] d2;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ment_t;

  logic        clk, rst;
  logic        mem_valid, mem_ready, alu_valid, alu_ready, wb_stall, RegWrite;
  logic [4:0]  mem_rd, alu_rd, rd, fwd_rs1, fwd_rs2;
  logic [31:0] mem_data, alu_data, write_data, fwd_data1, fwd_data2;
  logic        fwd_hit1, fwd_hit2;
  logic [2:0]  count;

  int          nChecks = 0;
  int          nFails  = 0;
  ment_t       mq[$];
  logic [4:0]  wlog[$];
  vec_t        vecs[15];

  reg_writeback_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .wb_stall   (wb_stall),
    .rd         (rd),
    .write_data (write_data),
    .RegWrite   (RegWrite),
    .fwd_rs1    (fwd_rs1),
    .fwd_hit1   (fwd_hit1),
    .fwd_data1  (fwd_data1),
    .fwd_rs2    (fwd_rs2),
    .fwd_hit2   (fwd_hit2),
    .fwd_data2  (fwd_data2),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t S(logic mv, logic [4:0] mrd, logic [31:0] md,
                              logic av, logic [4:0] ard, logic [31:0] ad,
                              logic st, logic [4:0] r1, logic [4:0] r2);
    stim_t s;
    s.mv = mv; s.mrd = mrd; s.md = md;
    s.av = av; s.ard = ard; s.ad = ad;
    s.st = st; s.r1 = r1; s.r2 = r2;
    return s;
  endfunction

  function automatic exp_t E(logic mr, logic ar, logic we, logic [4:0] erd,
                             logic [31:0] wd, logic [2:0] cnt,
                             logic h1, logic [31:0] d1, logic h2, logic [31:0] d2);
    exp_t e;
    e.mr = mr; e.ar = ar; e.we = we; e.rd = erd; e.wd = wd; e.cnt = cnt;
    e.h1 = h1; e.d1 = d1; e.h2 = h2; e.d2 = d2;
    return e;
  endfunction

  // Reference model: occupancy and readiness come from the queue size,
  // forwarding searches the queue from its youngest end.
  function automatic exp_t modelExpect(stim_t s);
    exp_t e;
    int   n;
    n     = mq.size();
    e.mr  = (n < 4);
    e.ar  = (n < 4) && !s.mv;
    e.we  = (n != 0) && !s.st;
    e.rd  = (n != 0) ? mq[0].rd   : 5'd0;
    e.wd  = (n != 0) ? mq[0].data : 32'd0;
    e.cnt = 3'(n);
    e.h1 = 1'b0; e.d1 = 32'd0; e.h2 = 1'b0; e.d2 = 32'd0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!e.h1 && s.r1 != 0 && mq[i].rd == s.r1) begin e.h1 = 1'b1; e.d1 = mq[i].data; end
      if (!e.h2 && s.r2 != 0 && mq[i].rd == s.r2) begin e.h2 = 1'b1; e.d2 = mq[i].data; end
    end
    return e;
  endfunction

  task automatic modelUpdate(input stim_t s, input exp_t e);
    ment_t m;
    if (e.we) void'(mq.pop_front());
    if (s.mv && e.mr) begin
      if (s.mrd != 0) begin m.rd = s.mrd; m.data = s.md; mq.push_back(m); end
    end else if (s.av && e.ar && s.ard != 0) begin
      m.rd = s.ard; m.data = s.ad; mq.push_back(m);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    mem_valid = s.mv; mem_rd = s.mrd; mem_data = s.md;
    alu_valid = s.av; alu_rd = s.ard; alu_data = s.ad;
    wb_stall  = s.st; fwd_rs1 = s.r1; fwd_rs2 = s.r2;
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e);
    checkField({tag, " mem_ready"},  32'(mem_ready),  32'(e.mr));
    checkField({tag, " alu_ready"},  32'(alu_ready),  32'(e.ar));
    checkField({tag, " RegWrite"},   32'(RegWrite),   32'(e.we));
    checkField({tag, " rd"},         32'(rd),         32'(e.rd));
    checkField({tag, " write_data"}, write_data,      e.wd);
    checkField({tag, " count"},      32'(count),      32'(e.cnt));
    checkField({tag, " fwd_hit1"},   32'(fwd_hit1),   32'(e.h1));
    checkField({tag, " fwd_data1"},  fwd_data1,       e.d1);
    checkField({tag, " fwd_hit2"},   32'(fwd_hit2),   32'(e.h2));
    checkField({tag, " fwd_data2"},  fwd_data2,       e.d2);
  endtask

  // One model-checked cycle; entered and left at posedge + 1.
  task automatic runCycle(input stim_t s, input string tag);
    exp_t e;
    applyStimulus(s);
    #3;
    e = modelExpect(s);
    checkOutput(tag, e);
    if (RegWrite === 1'b1) wlog.push_back(rd);
    @(posedge clk);
    #1;
    modelUpdate(s, e);
  endtask

  initial begin
    stim_t idle;
    stim_t s;
    idle = S(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Directed vectors: inputs of one cycle and the outputs expected before its edge.
    vecs[0]  = '{S(0,0,0, 1,5,32'hDEADBEEF, 0,5,0), E(1,1,0,0,0,0, 0,0,0,0)};
    vecs[1]  = '{S(0,0,0, 0,0,0, 0,5,0),            E(1,1,1,5,32'hDEADBEEF,1, 1,32'hDEADBEEF,0,0)};
    vecs[2]  = '{S(0,0,0, 0,0,0, 0,5,0),            E(1,1,0,0,0,0, 0,0,0,0)};
    vecs[3]  = '{S(1,3,32'h11, 1,4,32'h22, 0,3,4),  E(1,0,0,0,0,0, 0,0,0,0)};
    vecs[4]  = '{S(0,0,0, 1,4,32'h22, 0,3,4),       E(1,1,1,3,32'h11,1, 1,32'h11,0,0)};
    vecs[5]  = '{S(0,0,0, 0,0,0, 0,3,4),            E(1,1,1,4,32'h22,1, 0,0,1,32'h22)};
    vecs[6]  = '{S(0,0,0, 0,0,0, 0,3,4),            E(1,1,0,0,0,0, 0,0,0,0)};
    vecs[7]  = '{S(0,0,0, 1,0,32'h55, 0,0,0),       E(1,1,0,0,0,0, 0,0,0,0)};
    vecs[8]  = '{S(0,0,0, 0,0,0, 0,0,0),            E(1,1,0,0,0,0, 0,0,0,0)};
    vecs[9]  = '{S(0,0,0, 1,7,32'hA, 1,7,0),        E(1,1,0,0,0,0, 0,0,0,0)};
    vecs[10] = '{S(0,0,0, 1,7,32'hB, 1,7,0),        E(1,1,0,7,32'hA,1, 1,32'hA,0,0)};
    vecs[11] = '{S(0,0,0, 0,0,0, 1,7,0),            E(1,1,0,7,32'hA,2, 1,32'hB,0,0)};
    vecs[12] = '{S(0,0,0, 0,0,0, 0,7,0),            E(1,1,1,7,32'hA,2, 1,32'hB,0,0)};
    vecs[13] = '{S(0,0,0, 0,0,0, 0,7,0),            E(1,1,1,7,32'hB,1, 1,32'hB,0,0)};
    vecs[14] = '{S(0,0,0, 0,0,0, 0,7,0),            E(1,1,0,0,0,0, 0,0,0,0)};

    // Reset with traffic present: nothing is offered or accepted.
    rst = 1'b1;
    applyStimulus(S(1,9,32'h99, 1,8,32'h88, 0,9,8));
    @(posedge clk); #1;
    @(posedge clk); #3;
    checkField("reset mem_ready", 32'(mem_ready), 0);
    checkField("reset alu_ready", 32'(alu_ready), 0);
    checkField("reset RegWrite",  32'(RegWrite),  0);
    checkField("reset fwd_hit1",  32'(fwd_hit1),  0);
    checkField("reset fwd_data1", fwd_data1,      0);
    checkField("reset count",     32'(count),     0);
    applyStimulus(idle);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].s);
      #3;
      checkOutput($sformatf("vec%0d", i), vecs[i].e);
      @(posedge clk);
      #1;
    end

    // Fill under stall, hold a fifth result, then drain in order.
    mq.delete();
    wlog.delete();
    for (int i = 0; i < 4; i++)
      runCycle(S(0,0,0, 1,5'(10 + i),32'(100 + i), 1,0,0), $sformatf("fill%0d", i));
    applyStimulus(S(0,0,0, 1,14,32'h114, 1,0,0));
    #3;
    checkField("full count",     32'(count),     4);
    checkField("full mem_ready", 32'(mem_ready), 0);
    checkField("full alu_ready", 32'(alu_ready), 0);
    @(posedge clk); #1;
    runCycle(S(0,0,0, 1,14,32'h114, 1,0,0), "hold");
    runCycle(S(0,0,0, 1,14,32'h114, 0,0,0), "release0");
    runCycle(S(0,0,0, 1,14,32'h114, 0,0,0), "release1");
    for (int i = 0; i < 5; i++) runCycle(idle, $sformatf("drain%0d", i));
    checkField("drain length", 32'(wlog.size()), 5);
    for (int i = 0; i < 5 && i < wlog.size(); i++)
      checkField($sformatf("drain order %0d", i), 32'(wlog[i]), 32'(10 + i));

    // Mid-operation reset discards pending entries.
    for (int i = 0; i < 3; i++)
      runCycle(S(0,0,0, 1,5'(20 + i),32'(200 + i), 1,0,0), $sformatf("pre_rst%0d", i));
    rst = 1'b1;
    applyStimulus(S(0,0,0, 1,9,32'h9, 0,20,22));
    #3;
    checkField("rst mid mem_ready", 32'(mem_ready), 0);
    checkField("rst mid alu_ready", 32'(alu_ready), 0);
    checkField("rst mid RegWrite",  32'(RegWrite),  0);
    checkField("rst mid fwd_hit1",  32'(fwd_hit1),  0);
    checkField("rst mid fwd_hit2",  32'(fwd_hit2),  0);
    checkField("rst mid fwd_data2", fwd_data2,      0);
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    for (int i = 0; i < 3; i++) runCycle(S(0,0,0, 0,0,0, 0,20,22), $sformatf("post_rst%0d", i));

    // Randomized traffic with small register indices to provoke matches.
    for (int i = 0; i < 400; i++) begin
      s = S($urandom_range(1), 5'($urandom_range(7)), $urandom,
            $urandom_range(1), 5'($urandom_range(7)), $urandom,
            ($urandom_range(9) < 3), 5'($urandom_range(7)), 5'($urandom_range(7)));
      runCycle(s, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
